// File: rtl/serial_word_collector_if.sv
// Serial bit input and parallel word output of the serial word collector.
// The collector sits on the slave side; the bit source and word consumer on the master side.
interface serial_word_collector_if #(
    parameter int WIDTH = 5
);
    logic             si_valid;
    logic             si_bit;
    logic             si_sof;
    logic             si_ready;
    logic [WIDTH-1:0] po_data;
    logic             po_valid;
    logic             po_ready;
    logic             err_sof;

    modport master (
        output si_valid, si_bit, si_sof, po_ready,
        input  si_ready, po_data, po_valid, err_sof
    );

    modport slave (
        input  si_valid, si_bit, si_sof, po_ready,
        output si_ready, po_data, po_valid, err_sof
    );
endinterface

// File: rtl/serial_word_collector.sv
// Assembles a framed serial bit stream into WIDTH-bit words on a valid/ready output.
// One finished word can wait in the shift stage while another sits in the output register.
module serial_word_collector #(
    parameter int WIDTH     = 5,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                    clk,
    input logic                    rst,
    serial_word_collector_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   sr_r, sr_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [WIDTH-1:0]   po_data_r, po_data_s;
    logic               po_valid_r, po_valid_s;
    logic               err_sof_r, err_sof_s;
    logic               accept_s;
    logic               out_free_s;
    logic               last_bit_s;
    logic [WIDTH-1:0]   word_s;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word, input logic b);
        if (MSB_FIRST) begin
            return {word[WIDTH-2:0], b};
        end else begin
            return {b, word[WIDTH-1:1]};
        end
    endfunction

    assign bus.si_ready = (state_r != FULL);
    assign bus.po_data  = po_data_r;
    assign bus.po_valid = po_valid_r;
    assign bus.err_sof  = err_sof_r;

    assign accept_s   = bus.si_valid & (state_r != FULL);
    assign out_free_s = ~po_valid_r | bus.po_ready;
    assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));
    assign word_s     = shift_in(sr_r, bus.si_bit);

    // Next-state, shift stage and output register load decisions.
    always_comb begin
        state_s    = state_r;
        sr_s       = sr_r;
        cnt_s      = cnt_r;
        po_data_s  = po_data_r;
        po_valid_s = po_valid_r & ~bus.po_ready;
        err_sof_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s & bus.si_sof) begin
                    sr_s    = shift_in({WIDTH{1'b0}}, bus.si_bit);
                    cnt_s   = CNT_W'(1);
                    state_s = COLLECT;
                end else begin
                    state_s = IDLE;
                end
            end
            COLLECT: begin
                if (accept_s & bus.si_sof) begin
                    // A new frame start restarts the word; the partial one is dropped.
                    err_sof_s = 1'b1;
                    sr_s      = shift_in({WIDTH{1'b0}}, bus.si_bit);
                    cnt_s     = CNT_W'(1);
                end else if (accept_s & last_bit_s) begin
                    sr_s  = word_s;
                    cnt_s = {CNT_W{1'b0}};
                    if (out_free_s) begin
                        po_data_s  = word_s;
                        po_valid_s = 1'b1;
                        state_s    = IDLE;
                    end else begin
                        state_s = FULL;
                    end
                end else if (accept_s) begin
                    sr_s  = word_s;
                    cnt_s = cnt_r + CNT_W'(1);
                end else begin
                    state_s = COLLECT;
                end
            end
            FULL: begin
                // Output register is occupied here, so po_ready drains and reloads at once.
                if (bus.po_ready) begin
                    po_data_s  = sr_r;
                    po_valid_s = 1'b1;
                    cnt_s      = {CNT_W{1'b0}};
                    state_s    = IDLE;
                end else begin
                    state_s = FULL;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, shift stage and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            sr_r       <= {WIDTH{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            po_data_r  <= {WIDTH{1'b0}};
            po_valid_r <= 1'b0;
            err_sof_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            sr_r       <= sr_s;
            cnt_r      <= cnt_s;
            po_data_r  <= po_data_s;
            po_valid_r <= po_valid_s;
            err_sof_r  <= err_sof_s;
        end
    end
endmodule
